// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: board-pin front end for the CPU.
//   - Two-flop synchronisers and a shared-tick debouncer on the switches and
//     the step button.
//   - A single-cycle cpu_en pulse generator with halt / slow / fast / step modes.
//   - Registered LED drive.
// Optional build macro CPU_CLOCK_CTRL_CYCLE_COUNT_EN adds a 32-bit count of
// cpu_en pulses on the cycle_count output.
module cpu_clock_ctrl #(
    parameter int SW_WIDTH        = 4,
    parameter int LED_WIDTH       = 4,
    parameter int RATIO_SLOW      = 100_000_000,
    parameter int RATIO_FAST      = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  switch_raw,
    input  logic                 step_raw,
    input  logic [1:0]           mode,
    input  logic [LED_WIDTH-1:0] led_in,
    output logic [SW_WIDTH-1:0]  switch_out,
    output logic                 cpu_en,
    output logic [LED_WIDTH-1:0] led_out
`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]          cycle_count
`endif
);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_FAST = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    // Switches and the step button share one synchroniser/debouncer vector;
    // the step button sits in the top bit.
    localparam int DB_BITS = SW_WIDTH + 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RATE_W  = $clog2(RATIO_SLOW);

    logic [DB_BITS-1:0] sync_meta;
    logic [DB_BITS-1:0] sync_q;
    logic [DB_W-1:0]    sample_cnt;
    logic               sample_tick;
    logic [DB_BITS-1:0] sample_prev;
    logic [DB_BITS-1:0] db_q;
    logic [DB_BITS-1:0] sample_agree;
    logic               step_db;
    logic               step_db_q;

    mode_e              mode_in;
    mode_e              mode_q;
    logic [RATE_W-1:0]  rate_cnt;
    logic [RATE_W-1:0]  rate_cnt_d;
    logic [RATE_W-1:0]  rate_max;
    logic               cpu_en_d;

    assign mode_in      = mode_e'(mode);
    assign sample_tick  = (sample_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign sample_agree = ~(sync_q ^ sample_prev);
    assign step_db      = db_q[SW_WIDTH];
    assign switch_out   = db_q[SW_WIDTH-1:0];
    assign rate_max     = (mode_q == MODE_FAST) ? RATE_W'(RATIO_FAST - 1)
                                                : RATE_W'(RATIO_SLOW - 1);

    // Two-flop synchroniser for every asynchronous board input.
    always_ff @(posedge clock) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, exactly like the hardware.
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {step_raw, switch_raw};
            sync_q    <= sync_meta;
        end
    end

    // Debouncer: a bit moves only when two consecutive sample ticks agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_cnt  <= '0;
            sample_prev <= '0;
            db_q        <= '0;
            step_db_q   <= 1'b0;
        end else begin
            sample_cnt <= sample_tick ? '0 : sample_cnt + DB_W'(1);
            if (sample_tick) begin
                sample_prev <= sync_q;
                db_q        <= (sync_q & sample_agree) | (db_q & ~sample_agree);
            end
            step_db_q <= step_db;
        end
    end

    // Next rate count and cpu_en; a mode change clears both and drops a step edge.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned and no latch is inferred.
        rate_cnt_d = '0;
        cpu_en_d   = 1'b0;
        if (mode_in == mode_q) begin
            case (mode_q)
                MODE_SLOW, MODE_FAST: begin
                    if (rate_cnt == rate_max) begin
                        cpu_en_d = 1'b1;
                    end else begin
                        rate_cnt_d = rate_cnt + RATE_W'(1);
                    end
                end
                MODE_STEP: cpu_en_d = step_db & ~step_db_q;
                default:   ;
            endcase
        end
    end

    // Mode, rate counter and cpu_en state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q   <= MODE_HALT;
            rate_cnt <= '0;
            cpu_en   <= 1'b0;
        end else begin
            mode_q   <= mode_in;
            rate_cnt <= rate_cnt_d;
            cpu_en   <= cpu_en_d;
        end
    end

    // LED drive: one register stage, independent of cpu_en.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_out <= '0;
        end else begin
            led_out <= led_in;
        end
    end

`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q;

    // Count cpu_en pulses; only reset clears it, wrap is natural 32-bit overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else if (cpu_en) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Parametrised successor to the fixed-ratio prescaler front end.
- Generates a single-cycle CPU clock enable (cpu_en) from the board clock, with four runtime modes: halt, slow run, fast run, single-step.
- Synchronises and debounces SW_WIDTH board switches plus one step button, and registers LED outputs.
- Sits between the board pins and mother_board; the CPU domain runs on clock gated by cpu_en, with no derived clocks.

Parameters:
SW_WIDTH, 4, number of switch inputs and debounced outputs
LED_WIDTH, 4, LED bus width
RATIO_SLOW, 100_000_000, clock cycles per cpu_en pulse in slow mode (>=2)
RATIO_FAST, 1_000_000, clock cycles per cpu_en pulse in fast mode (>=2, <=RATIO_SLOW)
DEBOUNCE_CYCLES, 1_000_000, debounce sample period in clock cycles (>=2)

Ports:
clock  input  1  board clock; sole clock
reset  input  1  synchronous, active-high reset
switch_raw  input  SW_WIDTH  asynchronous board switches
step_raw  input  1  asynchronous step push-button, active-high
mode  input  2  synchronous: 00 halt, 01 slow, 10 fast, 11 step
led_in  input  LED_WIDTH  LED value from mother_board
switch_out  output  SW_WIDTH  synchronised, debounced switches
cpu_en  output  1  one-cycle clock-enable pulse for the CPU
led_out  output  LED_WIDTH  registered LED drive

Behaviour:
- Reset (sync, active-high): cpu_en=0, switch_out=0, led_out=0. All counters, sync flops, sample registers, mode_q and step edge register are cleared to 0.
- Synchroniser: 2-flop chain on every switch_raw bit and on step_raw.
- Debounce:
  - A shared sample counter runs 0..DEBOUNCE_CYCLES-1 and raises sample_tick when it reaches DEBOUNCE_CYCLES-1, then wraps to 0.
  - On each sample_tick, every bit's synchronised value is stored in sample_prev.
  - An output bit (switch_out[i], step_db) takes the new sample only when the new sample equals sample_prev[i].
  - Net effect: a level must be seen on 2 consecutive ticks to propagate. Any pulse shorter than DEBOUNCE_CYCLES is never seen twice, so it is never propagated.
- Rate counter:
  - rate_cnt runs 0..R-1, where R=RATIO_SLOW in mode 01 and R=RATIO_FAST in mode 10.
  - cpu_en=1 (registered) for exactly one cycle when rate_cnt==R-1; rate_cnt then wraps to 0. Period is exactly R cycles.
  - Width is $clog2(RATIO_SLOW).
- Halt (00): cpu_en=0; rate_cnt held at 0.
- Step (11): cpu_en=1 for exactly one cycle, in the cycle after step_db rises 0->1. Holding the button gives no further pulses. Releasing gives no pulse. rate_cnt is held at 0.
- Mode change:
  - mode_q is the registered mode.
  - In any cycle where mode!=mode_q: rate_cnt<=0, cpu_en<=0, and any pending step edge is discarded.
  - The first pulse after entering slow or fast mode arrives R cycles later.
- Step edges while mode!=11 are ignored and not remembered.
- Switching from fast to slow while rate_cnt>=RATIO_FAST-1 is covered by the mode-change clear; there is no out-of-range count.
- led_out<=led_in every cycle: 1-cycle latency, independent of cpu_en.
- cpu_en is never high for two consecutive cycles in any mode.

Optional Feature:
Macro: CPU_CLOCK_CTRL_CYCLE_COUNT_EN
- Defined: adds output port cycle_count (32 bits).
  - Increments by 1 on every cycle in which cpu_en=1.
  - Wraps 0xFFFF_FFFF->0.
  - Cleared by reset only; mode changes do not clear it.
  - Value is registered; the increment is visible the cycle after the cpu_en pulse.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
(Bench overrides: RATIO_SLOW=10, RATIO_FAST=4, DEBOUNCE_CYCLES=3, SW_WIDTH=4.)
- Reset, then mode=10 for 40 cycles -> 10 cpu_en pulses, first at cycle 4 after mode applied, spacing exactly 4; switch to 01 -> counter cleared, next pulse 10 cycles later, then every 10.
- mode=00 for 50 cycles with step_raw toggling -> cpu_en never asserted; led_in=4'hA -> led_out=4'hA one cycle later.
- mode=11, step_raw held high 30 cycles then low 30, twice -> exactly 2 cpu_en pulses, each 1 cycle wide; no pulse on release.
- switch_raw 4'b0000->4'b0101 held stable -> switch_out=4'b0101 within 2+2*3+1 cycles; 1-cycle glitch on bit 3 -> switch_out[3] never changes.
- Assert reset mid-run in mode 10 with rate_cnt=2 and switch_out=4'b0101 -> next cycle cpu_en=0, switch_out=0, led_out=0; first pulse after release at 4 cycles.
- With CPU_CLOCK_CTRL_CYCLE_COUNT_EN: force counter to 0xFFFF_FFFE, produce 3 pulses -> cycle_count 0xFFFF_FFFF, 0x0, 0x1.
